// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor.
// Processes an n-bit add (X + Y + carryin) or subtract (X - Y) k bits per clock,
// least-significant digit first, taking D = n/k clocks per operation.
//
// Parameters:
//   n         operand/result width
//   k         digit width per clock; must divide n
// Ports:
//   Clock     rising-edge clock
//   Resetn    asynchronous active-low reset
//   Start     begin an operation (accepted in idle or on the Done cycle)
//   Sub       0 = add, 1 = subtract (sampled with Start)
//   carryin   add-mode carry-in (sampled with Start, ignored when Sub=1)
//   X, Y      operands (sampled with Start)
//   Busy      high while digits are being processed
//   Done      one-cycle pulse when S/carryout/Overflow are updated
//   S         result, held until the next operation completes
//   carryout  carry out of bit n-1 (subtract: 1 = no borrow)
//   Overflow  two's-complement overflow of the result
module addsub_serial #(
  parameter int unsigned n = 64,
  parameter int unsigned k = 8
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Start,
  input  logic         Sub,
  input  logic         carryin,
  input  logic [n-1:0] X,
  input  logic [n-1:0] Y,
  output logic         Busy,
  output logic         Done,
  output logic [n-1:0] S,
  output logic         carryout,
  output logic         Overflow
);

  localparam int unsigned D  = n / k;
  localparam int unsigned Cw = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e        state_q;
  logic [n-1:0]  a_q, b_q;     // operands, shifted right one digit per clock
  logic [n-1:0]  acc_q;        // partial result, digits enter from the top
  logic          c_q;
  logic [Cw-1:0] j_q;
  logic [n-1:0]  s_q;
  logic          cout_q, ovf_q, busy_q, done_q;

  logic [k:0]    digit;
  logic [n-1:0]  dsum_ext;
  logic [n-1:0]  acc_d;
  logic          last;

  always_comb begin
    digit    = {1'b0, a_q[k-1:0]} + {1'b0, b_q[k-1:0]} + {{k{1'b0}}, c_q};
    dsum_ext = '0;
    dsum_ext[k-1:0] = digit[k-1:0];
    // After D shifts the first digit has reached the bottom of the accumulator.
    acc_d    = (acc_q >> k) | (dsum_ext << (n - k));
    last     = (j_q == Cw'(D - 1));
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      j_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StFin: begin
          done_q <= 1'b0;
          if (Start) begin
            a_q     <= X;
            b_q     <= Sub ? ~Y : Y;
            c_q     <= Sub | carryin;
            j_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_q   <= a_q >> k;
          b_q   <= b_q >> k;
          c_q   <= digit[k];
          acc_q <= acc_d;
          j_q   <= j_q + Cw'(1);
          if (last) begin
            state_q <= StFin;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            s_q     <= acc_d;
            cout_q  <= digit[k];
            // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
            ovf_q   <= a_q[k-1] ^ b_q[k-1] ^ acc_d[n-1] ^ digit[k];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign S        = s_q;
  assign carryout = cout_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: four instances (n,k) = (8,2), (64,8), (64,64), (16,1)
// against an arithmetic reference model, plus directed n=8 vectors.
module tb_addsub_serial;

  localparam int NI = 4;
  localparam int NN [NI] = '{8, 64, 64, 16};
  localparam int KK [NI] = '{2, 8, 64, 1};

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start_i [NI];
  logic        sub_i   [NI];
  logic        cin_i   [NI];
  logic [63:0] x_i     [NI];
  logic [63:0] y_i     [NI];
  logic        busy_o  [NI];
  logic        done_o  [NI];
  logic        co_o    [NI];
  logic        ov_o    [NI];
  logic [63:0] s_o     [NI];
  logic [7:0]  s8;
  logic [63:0] s64a, s64b;
  logic [15:0] s16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addsub_serial #(.n(8), .k(2)) u_n8 (
    .Clock(clk), .Resetn(rstn), .Start(start_i[0]), .Sub(sub_i[0]), .carryin(cin_i[0]),
    .X(x_i[0][7:0]), .Y(y_i[0][7:0]), .Busy(busy_o[0]), .Done(done_o[0]), .S(s8),
    .carryout(co_o[0]), .Overflow(ov_o[0])
  );
  addsub_serial #(.n(64), .k(8)) u_n64k8 (
    .Clock(clk), .Resetn(rstn), .Start(start_i[1]), .Sub(sub_i[1]), .carryin(cin_i[1]),
    .X(x_i[1]), .Y(y_i[1]), .Busy(busy_o[1]), .Done(done_o[1]), .S(s64a),
    .carryout(co_o[1]), .Overflow(ov_o[1])
  );
  addsub_serial #(.n(64), .k(64)) u_n64k64 (
    .Clock(clk), .Resetn(rstn), .Start(start_i[2]), .Sub(sub_i[2]), .carryin(cin_i[2]),
    .X(x_i[2]), .Y(y_i[2]), .Busy(busy_o[2]), .Done(done_o[2]), .S(s64b),
    .carryout(co_o[2]), .Overflow(ov_o[2])
  );
  addsub_serial #(.n(16), .k(1)) u_n16 (
    .Clock(clk), .Resetn(rstn), .Start(start_i[3]), .Sub(sub_i[3]), .carryin(cin_i[3]),
    .X(x_i[3][15:0]), .Y(y_i[3][15:0]), .Busy(busy_o[3]), .Done(done_o[3]), .S(s16),
    .carryout(co_o[3]), .Overflow(ov_o[3])
  );

  assign s_o[0] = {56'd0, s8};
  assign s_o[1] = s64a;
  assign s_o[2] = s64b;
  assign s_o[3] = {48'd0, s16};

  // Reference arithmetic: returns {overflow, carryout, sum}.
  function automatic logic [65:0] ref_op(int nn, logic [63:0] x, logic [63:0] y,
                                         logic sb, logic ci);
    logic [64:0] mask, a, b, full;
    logic [63:0] s;
    logic        co, ov;
    mask = (65'd1 << nn) - 65'd1;
    a    = {1'b0, x} & mask;
    b    = {1'b0, y} & mask;
    if (sb) b = ~b & mask;
    full = a + b + (sb ? 65'd1 : {64'd0, ci});
    s    = full[63:0] & mask[63:0];
    co   = full[nn];
    ov   = (a[nn-1] == b[nn-1]) && (s[nn-1] != a[nn-1]);
    return {ov, co, s};
  endfunction

  // Cycle-level model: an accepted Start produces Done D edges later.
  int          cnt   [NI];
  logic [65:0] pend  [NI];
  logic [65:0] res_e [NI];
  logic        done_e[NI];

  always @(posedge clk or negedge rstn) begin
    for (int i = 0; i < NI; i++) begin
      if (!rstn) begin
        cnt[i] = 0; pend[i] = '0; res_e[i] = '0; done_e[i] = 1'b0;
      end else begin
        done_e[i] = 1'b0;
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            done_e[i] = 1'b1;
            res_e[i]  = pend[i];
          end
        end else if (start_i[i]) begin
          pend[i] = ref_op(NN[i], x_i[i], y_i[i], sub_i[i], cin_i[i]);
          cnt[i]  = NN[i] / KK[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic [67:0] act, exp;
      act = {busy_o[i], done_o[i], ov_o[i], co_o[i], s_o[i]};
      exp = {cnt[i] > 0, done_e[i], res_e[i]};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model_cmp inst%0d t=%0t got busy/done/ov/co/S=%h expected %h",
                 i, $time, act, exp);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Counts negedges from the one after the Start edge until Done (bounded).
  task automatic wait_done0(input string nm, output int cyc);
    cyc = 1;
    while (!done_o[0] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!done_o[0]) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout got no Done expected Done within 20 cycles", nm);
    end
  endtask

  task automatic run8(input string nm, input logic [7:0] xa, input logic [7:0] ya,
                      input logic sb, input logic ci, input logic [7:0] es,
                      input logic eco, input logic eov);
    int cyc;
    x_i[0] = {56'd0, xa}; y_i[0] = {56'd0, ya}; sub_i[0] = sb; cin_i[0] = ci;
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    // Scramble inputs while running; the result must not change.
    x_i[0] = {$urandom, $urandom}; y_i[0] = {$urandom, $urandom};
    sub_i[0] = ~sb; cin_i[0] = ~ci;
    wait_done0(nm, cyc);
    chk({nm, "_latency"}, 64'(cyc), 64'd5);
    chk({nm, "_S"}, {56'd0, s8}, {56'd0, es});
    chk({nm, "_carryout"}, {63'd0, co_o[0]}, {63'd0, eco});
    chk({nm, "_Overflow"}, {63'd0, ov_o[0]}, {63'd0, eov});
  endtask

  initial begin
    int cyc, ndone;
    for (int i = 0; i < NI; i++) begin
      start_i[i] = 1'b0; sub_i[i] = 1'b0; cin_i[i] = 1'b0; x_i[i] = '0; y_i[i] = '0;
    end
    #3;
    chk("reset_busy", {63'd0, busy_o[0]}, 64'd0);
    chk("reset_done", {63'd0, done_o[0]}, 64'd0);
    chk("reset_S", s_o[0], 64'd0);
    @(negedge clk); @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);

    run8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    @(negedge clk);
    run8("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    run8("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
    @(negedge clk); @(negedge clk);
    run8("add_ff_01_c", 8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
    // Back-to-back: Start on the Done cycle itself.
    run8("b2b_10_20", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);

    // Start during RUN is ignored.
    @(negedge clk); @(negedge clk);
    x_i[0] = 64'h12; y_i[0] = 64'h34; sub_i[0] = 1'b0; cin_i[0] = 1'b0; start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    @(negedge clk);
    x_i[0] = 64'hAA; y_i[0] = 64'h55; start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (done_o[0]) begin
        ndone++;
        chk("run_start_S", {56'd0, s8}, 64'h46);
      end
      @(negedge clk);
    end
    chk("run_start_done_count", 64'(ndone), 64'd1);

    // Reset during digit 2.
    x_i[0] = 64'h3C; y_i[0] = 64'h11; start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_busy", {63'd0, busy_o[0]}, 64'd0);
    chk("rst_mid_done", {63'd0, done_o[0]}, 64'd0);
    chk("rst_mid_S", s_o[0], 64'd0);
    chk("rst_mid_flags", {62'd0, co_o[0], ov_o[0]}, 64'd0);
    @(negedge clk);
    #2 rstn = 1'b1;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done_o[0]) ndone++;
    end
    chk("rst_no_done", 64'(ndone), 64'd0);
    run8("after_rst", 8'h3C, 8'h11, 1'b0, 1'b0, 8'h4D, 1'b0, 1'b0);

    // Model pinning against hand values at other widths.
    chk("ref_64_sub", ref_op(64, 64'd0, 64'd1, 1'b1, 1'b0)[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ref_16_ovf", {62'd0, ref_op(16, 64'h7FFF, 64'h1, 1'b0, 1'b0)[65:64]}, 64'd2);

    // Random concurrent regression on all instances.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        start_i[i] = ($urandom_range(0, 2) == 0);
        x_i[i]     = {$urandom, $urandom};
        y_i[i]     = {$urandom, $urandom};
        sub_i[i]   = $urandom_range(0, 1) == 1;
        cin_i[i]   = $urandom_range(0, 1) == 1;
      end
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) start_i[i] = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
